// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter in front of fifo_async: one requester owns the port for up to
// MAX_BURST words, and writes are suppressed while the FIFO reports full. Optional stall counter: FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]              ready_o,
    input  logic                            full_i,
    output logic                            write_en_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    output logic [15:0]                     stall_cnt_o
`endif
);

    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);
    localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NUM_REQ - 1);
    localparam logic [OWNER_W:0]   NUM_REQ_EXT = (OWNER_W + 1)'(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_reg, state_next;
    logic [OWNER_W-1:0]     owner_reg, owner_next;
    logic [OWNER_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [BURST_W-1:0]     burst_cnt_reg, burst_cnt_next;
    logic [OWNER_W-1:0]     pick;
    logic [OWNER_W-1:0]     owner_inc;
    logic [OWNER_W:0]       scan_idx;
    logic                   pick_found;
    logic                   owner_req;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_o[gi]  = busy_o && (owner_reg == OWNER_W'(gi));
            assign ready_o[gi]  = accept && (owner_reg == OWNER_W'(gi));
        end
    endgenerate

    assign busy_o     = (state_reg == GRANT);
    assign owner_req  = req_i[owner_reg];
    assign accept     = busy_o && owner_req && !full_i;
    assign write_en_o = accept;
    assign data_o     = busy_o ? data_arr[owner_reg] : '0;
    assign owner_inc  = (owner_reg == LAST_REQ) ? '0 : owner_reg + 1'b1;

    // First requester at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        pick       = rr_ptr_reg;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (OWNER_W + 1)'(i);
            if (scan_idx >= NUM_REQ_EXT) begin
                scan_idx = scan_idx - NUM_REQ_EXT;
            end
            if (!pick_found && req_i[scan_idx[OWNER_W-1:0]]) begin
                pick       = scan_idx[OWNER_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req_i) begin
                    state_next     = GRANT;
                    owner_next     = pick;
                    burst_cnt_next = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (burst_cnt_reg == LAST_BEAT) begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_inc;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                    end
                end else if (!owner_req) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_inc;
                end
                // Owner still requesting but FIFO full: hold everything, budget untouched.
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_reg <= '0;
        end else if (busy_o && owner_req && full_i && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: random producers and FIFO-full pattern, with a
// round-robin/burst reference model checking every cycle and directed scenario checks.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    ready_o;
    logic            full_i;
    logic            write_en_o;
    logic [DW-1:0]   data_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0]     stall_cnt_o;
`endif

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .full_i     (full_i),
        .write_en_o (write_en_o),
        .data_o     (data_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Scoreboard: the word each requester is currently presenting (pushed by stimulus).
    logic [DW-1:0] pend_q [N][$];
    int            left_words [N];
    int            seq [N];
    int            presented = 0;
    int            withdrawn = 0;
    int            writes_seen = 0;

    // Logs filled by the monitor for directed checks.
    int            wr_cyc [$];
    logic [DW-1:0] wr_dat [$];
    logic [N-1:0]  grant_log [$];
    int            dut_stalls = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    bit            prev_busy = 1'b0;

    // Reference model state, in terms of grants and words.
    bit            m_busy = 1'b0;
    int            m_owner = 0;
    int            m_ptr = 0;
    int            m_words = 0;
    int            m_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor + reference model: sample on the falling edge, then advance the model
    // to what the next rising edge should do.
    always @(negedge clk_i) begin
        if (mon_en) begin
            logic [N-1:0]  exp_grant;
            logic [N-1:0]  exp_ready;
            logic [DW-1:0] exp_word;
            bit            acc;
            cyc++;
            exp_grant = '0;
            exp_ready = '0;
            acc = m_busy && req_i[m_owner] && !full_i;
            if (m_busy) exp_grant[m_owner] = 1'b1;
            if (acc)    exp_ready[m_owner] = 1'b1;
            check("grant_o", 64'(grant_o), 64'(exp_grant));
            check("busy_o", 64'(busy_o), 64'(m_busy));
            check("write_en_o", 64'(write_en_o), 64'(acc));
            check("ready_o", 64'(ready_o), 64'(exp_ready));
            if (acc) begin
                if (pend_q[m_owner].size() == 0) begin
                    check("scoreboard_empty", 64'(1), 64'(0));
                end else begin
                    exp_word = pend_q[m_owner].pop_front();
                    check("data_o", 64'(data_o), 64'(exp_word));
                end
                writes_seen++;
                wr_cyc.push_back(cyc);
                wr_dat.push_back(data_o);
                $display("WR cycle=%0d req=%0d data=%08h", cyc, m_owner, data_o);
            end else if (!m_busy) begin
                check("data_o_idle", 64'(data_o), 64'(0));
            end
            if (busy_o && !prev_busy) grant_log.push_back(grant_o);
            prev_busy = busy_o;
            if (grant_o == 4'b0100 && req_i[2] && full_i && !write_en_o) dut_stalls++;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
            check("stall_cnt_o", 64'(stall_cnt_o), 64'(m_stall));
`endif
            if (reset_i) begin
                m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_words = 0; m_stall = 0;
            end else if (!m_busy) begin
                if (req_i != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (req_i[(m_ptr + i) % N]) begin
                            m_owner = (m_ptr + i) % N;
                            break;
                        end
                    end
                    m_busy  = 1'b1;
                    m_words = 0;
                end
            end else if (acc) begin
                m_words++;
                if (m_words == MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end else if (!req_i[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end
    end

    // Producers: hold a word until ready, optionally withdraw it, present new ones at random.
    task automatic run_cycles(input int ncyc, input int p_req, input int p_full,
                              input logic [N-1:0] en, input int p_drop, input int p_rst);
        logic [N-1:0]  rdy;
        logic [DW-1:0] word;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_i);
            rdy = ready_o;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rdy[k]) begin
                    req_i[k] = 1'b0;
                end else if (req_i[k] && p_drop > 0 && ($urandom % 100) < p_drop) begin
                    req_i[k] = 1'b0;
                    pend_q[k].delete();
                    withdrawn++;
                end
                if (!req_i[k] && en[k] && left_words[k] > 0 && ($urandom % 100) < p_req) begin
                    word = {8'(k), 8'($urandom), 16'(seq[k])};
                    seq[k]++;
                    left_words[k]--;
                    data_i[k*DW +: DW] = word;
                    req_i[k] = 1'b1;
                    pend_q[k].push_back(word);
                    presented++;
                end
            end
            full_i  = (($urandom % 100) < p_full);
            reset_i = (($urandom % 100) < p_rst);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    initial begin
        int budget;
        reset_i = 1'b1;
        req_i   = '0;
        data_i  = '0;
        full_i  = 1'b0;
        for (int k = 0; k < N; k++) begin
            seq[k] = 1;
            left_words[k] = 0;
        end
        @(posedge clk_i);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        check("reset_outputs", 64'({grant_o, busy_o, write_en_o, ready_o}), 64'(0));
        check("reset_data_o", 64'(data_o), 64'(0));

        // Single requester: 1..4, one bubble, 5..6.
        wr_cyc.delete(); wr_dat.delete();
        left_words[0] = 6;
        run_cycles(20, 100, 0, 4'b0001, 0, 0);
        check("single_count", 64'(wr_dat.size()), 64'(6));
        if (wr_dat.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("single_word", 64'(wr_dat[i][15:0]), 64'(i + 1));
                if (i > 0) check("single_gap", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'((i == 4) ? 2 : 1));
            end
        end

        // Full stall on requester 2 after its first write.
        wr_cyc.delete(); wr_dat.delete();
        dut_stalls = 0;
        left_words[2] = 4;
        run_cycles(2, 100, 0, 4'b0100, 0, 0);
        run_cycles(5, 100, 100, 4'b0100, 0, 0);
        run_cycles(12, 100, 0, 4'b0100, 0, 0);
        check("stall_writes", 64'(wr_dat.size()), 64'(4));
        check("stall_cycles", 64'(dut_stalls), 64'(5));
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        check("stall_cnt_final", 64'(stall_cnt_o), 64'(5));
`endif

        // All requesters busy after a reset: grants rotate starting at requester 0.
        reset_pulse();
        grant_log.delete();
        for (int k = 0; k < N; k++) left_words[k] = 8;
        run_cycles(60, 100, 0, 4'b1111, 0, 0);
        check("rr_grant_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            logic [N-1:0] g;
            g = '0;
            g[i % N] = 1'b1;
            check("rr_grant_seq", 64'(grant_log[i]), 64'(g));
        end

        // Random traffic: contention, FIFO full, withdrawn requests, stray resets.
        for (int k = 0; k < N; k++) left_words[k] = 150;
        run_cycles(1500, 60, 25, 4'b1111, 4, 1);

        // Drain whatever is still being presented.
        full_i  = 1'b0;
        reset_i = 1'b0;
        budget  = 0;
        while (req_i != '0 && budget < 200) begin
            run_cycles(1, 0, 0, 4'b0000, 0, 0);
            budget++;
        end
        check("drain_timeout", 64'(req_i != '0), 64'(0));
        run_cycles(3, 0, 0, 4'b0000, 0, 0);
        check("word_count", 64'(writes_seen), 64'(presented - withdrawn));
        for (int k = 0; k < N; k++) check("queue_empty", 64'(pend_q[k].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
